tdm_demux: RTL and testbench
============================

# tdm_demux

Receive-side partner of the team's mux datapath: accepts a time-division-multiplexed serial bit stream, with one frame carrying one word per channel, and splits it back into per-channel parallel words. Each completed word is reported with a one-cycle strobe. The latest word for every channel is held in a register bank. Sits at the receive end of the serial link, between the bit source and channel consumers.

## Interface
- `N_CHANNELS`, default 4: channels per frame, ≥2.
- `WIDTH`, default 8: bits per channel word, ≥2.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_bit` in 1: serial data bit.
- `in_valid` in 1: `in_bit`/`frame_start` sampled only when high.
- `frame_start` in 1: qualified by `in_valid`; marks first bit of channel 0.
- `word_data` out WIDTH: most recently completed word.
- `word_channel` out $clog2(N_CHANNELS): channel index of `word_data`.
- `word_valid` out 1: one-cycle strobe, new word on `word_data`.
- `frame_done` out 1: one-cycle strobe, coincident with `word_valid` of last channel.
- `sync_error` out 1: one-cycle strobe, frame_start arrived mid-frame.
- `ch_data` out N_CHANNELS*WIDTH: register bank; channel k at bits [k*WIDTH +: WIDTH].

## Operation
- FSM states: IDLE, RECEIVING.
- IDLE: `in_valid && !frame_start` → bit discarded, no error. `in_valid && frame_start` → bit becomes MSB of channel 0; bit_cnt=1, ch=0; go RECEIVING.
- RECEIVING, `in_valid && !frame_start`: shift bit in (MSB first), bit_cnt++.
- Word complete (bit_cnt reaches WIDTH on this bit): `word_data`←assembled word, `word_channel`←ch, `word_valid`=1, `ch_data[ch]`←word, bit_cnt=0, ch++.
- Completed word has ch==N_CHANNELS-1: also `frame_done`=1; go IDLE.
- RECEIVING, `in_valid && frame_start`: `sync_error`=1; partial word discarded (no `word_valid`, `ch_data` untouched); bit becomes MSB of channel 0; bit_cnt=1, ch=0; stay RECEIVING. Applies even on what would have been the frame's last bit.
- `in_valid` low: no state change, counters hold; gaps of any length allowed mid-word.
- Arithmetic: bit_cnt width $clog2(WIDTH+1), ch width $clog2(N_CHANNELS); neither wraps beyond its limit (reset to 0 on completion).

## Timing
- All outputs registered. Reset values: `word_data`=0, `word_channel`=0, `word_valid`=0, `frame_done`=0, `sync_error`=0, `ch_data`=0, state IDLE, counters 0.
- Latency: strobes and updated `word_data`/`word_channel`/`ch_data` are visible in the cycle after the edge sampling the word's last bit.
- Strobes high exactly one cycle. `word_data`/`word_channel` hold until the next completed word.
- Back-to-back frames: `frame_start` on the cycle after a frame's last bit is accepted, no gap and no error.
- `rst` mid-frame: immediate return to reset values, partial word and bank cleared. First accepted bit after release needs `frame_start`.

## Structure
- Package `tdm_pkg`: state enum (`TDM_IDLE`, `TDM_RECEIVING`) and default-parameter constants.
- One sub-module: `shift_in_register` (WIDTH-bit MSB-first shift register with enable and synchronous clear), instantiated once. FSM, counters and bank live in `tdm_demux`.

## Test plan
Use N_CHANNELS=4, WIDTH=8, `in_valid` held high unless stated.
- Reset then clean frame 0xA5,0x3C,0xFF,0x01 → four `word_valid` strobes 8 cycles apart with channels 0..3; `frame_done` with channel 3; `ch_data`=0x01FF3CA5.
- Same frame with `in_valid` low for 3 cycles every other bit → identical words and `ch_data`; strobes spaced by the stretched bit count.
- Bits with no `frame_start` while IDLE (0xFF pattern) → no strobes, `ch_data` stays 0.
- `frame_start` on bit 5 of channel 2 → `sync_error` one cycle; channels 0/1 kept, channel 2 not written. New frame 0x11,0x22,0x33,0x44 → `ch_data`=0x44332211.
- Two frames back-to-back (0x01..0x04 then 0x10..0x40) → 8 strobes, two `frame_done`, no `sync_error`, final `ch_data`=0x40302010.
- `rst` asserted mid-channel-1 → all outputs 0 immediately. After release, a clean frame decodes correctly.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and default sizing for the TDM receive demultiplexer.
// Imported by the interface, the top and its helpers.
package tdm_pkg;

  typedef enum logic {
    TDM_IDLE,
    TDM_RECEIVING
  } tdm_state_t;

  localparam int TDM_N_CHANNELS = 4;
  localparam int TDM_WIDTH      = 8;

endpackage

// File: rtl/tdm_demux_if.sv
// Serial input and demultiplexed output bundle of tdm_demux.
// master = bit source/consumer side, slave = the demux itself.
interface tdm_demux_if
  import tdm_pkg::*;
#(
  parameter int N_CHANNELS = TDM_N_CHANNELS,
  parameter int WIDTH      = TDM_WIDTH
) ();

  localparam int CHW = $clog2(N_CHANNELS);

  logic                         in_bit;
  logic                         in_valid;
  logic                         frame_start;
  logic [WIDTH-1:0]             word_data;
  logic [CHW-1:0]               word_channel;
  logic                         word_valid;
  logic                         frame_done;
  logic                         sync_error;
  logic [N_CHANNELS*WIDTH-1:0]  ch_data;

  modport master (
    output in_bit,
    output in_valid,
    output frame_start,
    input  word_data,
    input  word_channel,
    input  word_valid,
    input  frame_done,
    input  sync_error,
    input  ch_data
  );

  modport slave (
    input  in_bit,
    input  in_valid,
    input  frame_start,
    output word_data,
    output word_channel,
    output word_valid,
    output frame_done,
    output sync_error,
    output ch_data
  );

endinterface

// File: rtl/shift_in_register.sv
// MSB-first serial-in shift register with enable and sync clear.
// o_next is the value the register takes on this edge when enabled.
module shift_in_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_next
);

  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_base;

  // Clear acts before the shift so a restart loads the bit fresh
  always_comb begin
    w_base = i_clr ? '0 : r_data;
    o_next = {w_base[WIDTH-2:0], i_bit};
  end

  // Shift on enable, otherwise honour a lone clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_data <= '0;
    else if (i_en)  r_data <= o_next;
    else if (i_clr) r_data <= '0;
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM serial-to-parallel demultiplexer: frame FSM, counters,
// registered word strobes and the per-channel register bank.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int N_CHANNELS = TDM_N_CHANNELS,
  parameter int WIDTH      = TDM_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  tdm_demux_if.slave  bus
);

  localparam int CHW = $clog2(N_CHANNELS);
  localparam int CW  = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CHW-1:0] LAST_CH  = CHW'(N_CHANNELS - 1);

  tdm_state_t r_state, w_state_n;
  logic [CW-1:0]  r_bit_cnt, w_bit_cnt_n;
  logic [CHW-1:0] r_ch, w_ch_n;

  logic w_shift_en;
  logic w_shift_clr;
  logic w_word_done;
  logic w_frame_done;
  logic w_sync_err;
  logic [WIDTH-1:0] w_word;

  logic [WIDTH-1:0] r_word_data;
  logic [CHW-1:0]   r_word_channel;
  logic             r_word_valid;
  logic             r_frame_done;
  logic             r_sync_error;
  logic [N_CHANNELS-1:0][WIDTH-1:0] r_bank;

  shift_in_register #(.WIDTH(WIDTH)) u_sreg (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_shift_en),
    .i_clr  (w_shift_clr),
    .i_bit  (bus.in_bit),
    .o_next (w_word)
  );

  // Frame sequencing: next state, counters and word/frame events
  always_comb begin
    w_state_n    = r_state;
    w_bit_cnt_n  = r_bit_cnt;
    w_ch_n       = r_ch;
    w_shift_en   = 1'b0;
    w_shift_clr  = 1'b0;
    w_word_done  = 1'b0;
    w_frame_done = 1'b0;
    w_sync_err   = 1'b0;
    unique case (r_state)
      TDM_IDLE: begin
        if (bus.in_valid && bus.frame_start) begin
          w_shift_en  = 1'b1;
          w_shift_clr = 1'b1;
          w_bit_cnt_n = CW'(1);
          w_ch_n      = '0;
          w_state_n   = TDM_RECEIVING;
        end
      end
      TDM_RECEIVING: begin
        if (bus.in_valid && bus.frame_start) begin
          w_sync_err  = 1'b1;
          w_shift_en  = 1'b1;
          w_shift_clr = 1'b1;
          w_bit_cnt_n = CW'(1);
          w_ch_n      = '0;
        end else if (bus.in_valid) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            w_word_done = 1'b1;
            w_bit_cnt_n = '0;
            if (r_ch == LAST_CH) begin
              w_frame_done = 1'b1;
              w_ch_n       = '0;
              w_state_n    = TDM_IDLE;
            end else begin
              w_ch_n = r_ch + CHW'(1);
            end
          end else begin
            w_bit_cnt_n = r_bit_cnt + CW'(1);
          end
        end
      end
      default: w_state_n = TDM_IDLE;
    endcase
  end

  // FSM state and position counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= TDM_IDLE;
      r_bit_cnt <= '0;
      r_ch      <= '0;
    end else begin
      r_state   <= w_state_n;
      r_bit_cnt <= w_bit_cnt_n;
      r_ch      <= w_ch_n;
    end
  end

  // Registered strobes, latest word and the channel bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word_data    <= '0;
      r_word_channel <= '0;
      r_word_valid   <= 1'b0;
      r_frame_done   <= 1'b0;
      r_sync_error   <= 1'b0;
      r_bank         <= '0;
    end else begin
      r_word_valid <= w_word_done;
      r_frame_done <= w_frame_done;
      r_sync_error <= w_sync_err;
      if (w_word_done) begin
        r_word_data    <= w_word;
        r_word_channel <= r_ch;
        r_bank[r_ch]   <= w_word;
      end
    end
  end

  assign bus.word_data    = r_word_data;
  assign bus.word_channel = r_word_channel;
  assign bus.word_valid   = r_word_valid;
  assign bus.frame_done   = r_frame_done;
  assign bus.sync_error   = r_sync_error;
  assign bus.ch_data      = r_bank;

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed frames plus random
// traffic against a frame-position reference model.
module tb_tdm_demux;

  localparam int NC = 4;
  localparam int W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tdm_demux_if #(.N_CHANNELS(NC), .WIDTH(W)) bus ();

  tdm_demux #(.N_CHANNELS(NC), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_words  = 0;
  int n_frames = 0;
  int n_sync   = 0;

  // Reference: pos = bits accepted in current frame, -1 when idle
  int         m_pos;
  logic [W-1:0] m_acc;
  logic [W-1:0] e_word_data;
  logic [1:0]   e_word_channel;
  logic         e_word_valid;
  logic         e_frame_done;
  logic         e_sync_error;
  logic [W-1:0] e_bank [NC];

  function automatic logic [NC*W-1:0] e_ch_data();
    logic [NC*W-1:0] r;
    for (int k = 0; k < NC; k++) r[k*W +: W] = e_bank[k];
    return r;
  endfunction

  task automatic model_reset();
    m_pos          = -1;
    m_acc          = '0;
    e_word_data    = '0;
    e_word_channel = '0;
    e_word_valid   = 1'b0;
    e_frame_done   = 1'b0;
    e_sync_error   = 1'b0;
    for (int k = 0; k < NC; k++) e_bank[k] = '0;
  endtask

  task automatic model_step(input logic v, input logic b, input logic fs);
    e_word_valid = 1'b0;
    e_frame_done = 1'b0;
    e_sync_error = 1'b0;
    if (v) begin
      if (fs) begin
        e_sync_error = (m_pos > 0);
        m_acc = W'(b);
        m_pos = 1;
      end else if (m_pos > 0) begin
        m_acc = {m_acc[W-2:0], b};
        m_pos++;
        if (m_pos % W == 0) begin
          e_word_valid   = 1'b1;
          e_word_data    = m_acc;
          e_word_channel = 2'(m_pos / W - 1);
          e_bank[m_pos / W - 1] = m_acc;
          if (m_pos == NC * W) begin
            e_frame_done = 1'b1;
            m_pos = -1;
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    checks++;
    assert (bus.word_data === e_word_data) else begin
      failures++;
      $error("FAIL word_data got=%h exp=%h", bus.word_data, e_word_data);
    end
    checks++;
    assert (bus.word_channel === e_word_channel) else begin
      failures++;
      $error("FAIL word_channel got=%0d exp=%0d", bus.word_channel, e_word_channel);
    end
    checks++;
    assert (bus.word_valid === e_word_valid) else begin
      failures++;
      $error("FAIL word_valid got=%b exp=%b", bus.word_valid, e_word_valid);
    end
    checks++;
    assert (bus.frame_done === e_frame_done) else begin
      failures++;
      $error("FAIL frame_done got=%b exp=%b", bus.frame_done, e_frame_done);
    end
    checks++;
    assert (bus.sync_error === e_sync_error) else begin
      failures++;
      $error("FAIL sync_error got=%b exp=%b", bus.sync_error, e_sync_error);
    end
    checks++;
    assert (bus.ch_data === e_ch_data()) else begin
      failures++;
      $error("FAIL ch_data got=%h exp=%h", bus.ch_data, e_ch_data());
    end
  endtask

  task automatic cyc(input logic v, input logic b, input logic fs);
    bus.in_valid    = v;
    bus.in_bit      = b;
    bus.frame_start = fs;
    if (rst) model_reset();
    else     model_step(v, b, fs);
    @(posedge clk);
    #1;
    if (bus.word_valid === 1'b1) n_words++;
    if (bus.frame_done === 1'b1) n_frames++;
    if (bus.sync_error === 1'b1) n_sync++;
    check_outputs();
  endtask

  function automatic logic frame_bit(input logic [NC*W-1:0] fr, input int i);
    return fr[(i / W) * W + (W - 1) - (i % W)];
  endfunction

  task automatic send_bits(input logic [NC*W-1:0] fr, input int nbits,
                           input int gap);
    for (int i = 0; i < nbits; i++) begin
      cyc(1'b1, frame_bit(fr, i), i == 0);
      if (gap > 0 && i % 2 == 1)
        for (int g = 0; g < gap; g++)
          cyc(1'b0, 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic expect_eq(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_bit      = 1'b0;
    bus.frame_start = 1'b0;
    model_reset();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);

    // clean frame
    n_words = 0; n_frames = 0;
    send_bits(32'h01FF3CA5, 32, 0);
    checks++;
    assert (bus.ch_data === 32'h01FF3CA5) else begin
      failures++;
      $error("FAIL clean_bank got=%h exp=%h", bus.ch_data, 32'h01FF3CA5);
    end
    expect_eq("clean_words", n_words, 4);
    expect_eq("clean_frames", n_frames, 1);

    // same frame with stretched bits
    send_bits(32'h01FF3CA5, 32, 3);
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    assert (bus.ch_data === 32'h01FF3CA5) else begin
      failures++;
      $error("FAIL gap_bank got=%h exp=%h", bus.ch_data, 32'h01FF3CA5);
    end

    // idle bits without frame_start are dropped
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    n_words = 0;
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 1'b0);
    expect_eq("idle_words", n_words, 0);

    // frame_start on bit 5 of channel 2
    n_sync = 0;
    send_bits(32'hDDCCBBAA, 20, 0);
    send_bits(32'h44332211, 32, 0);
    expect_eq("sync_count", n_sync, 1);
    checks++;
    assert (bus.ch_data === 32'h44332211) else begin
      failures++;
      $error("FAIL resync_bank got=%h exp=%h", bus.ch_data, 32'h44332211);
    end

    // back-to-back frames
    n_words = 0; n_frames = 0; n_sync = 0;
    send_bits(32'h04030201, 32, 0);
    send_bits(32'h40302010, 32, 0);
    expect_eq("b2b_words", n_words, 8);
    expect_eq("b2b_frames", n_frames, 2);
    expect_eq("b2b_sync", n_sync, 0);
    checks++;
    assert (bus.ch_data === 32'h40302010) else begin
      failures++;
      $error("FAIL b2b_bank got=%h exp=%h", bus.ch_data, 32'h40302010);
    end

    // reset mid channel 1, asynchronous clear
    send_bits(32'h0F0E0D0C, 12, 0);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
    send_bits(32'h5A6B7C8D, 32, 1);
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    assert (bus.ch_data === 32'h5A6B7C8D) else begin
      failures++;
      $error("FAIL post_rst_bank got=%h exp=%h", bus.ch_data, 32'h5A6B7C8D);
    end

    // random whole frames with random gaps
    for (int f = 0; f < 6; f++)
      send_bits(32'($urandom), 32, int'($urandom_range(0, 2)));

    // random raw traffic including stray frame_start
    for (int i = 0; i < 600; i++)
      cyc(($urandom % 4) != 0, 1'($urandom), ($urandom % 48) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
